// File: rtl/flash_mem_if.sv
// flash_mem_if: Avalon-MM read-only bundle shared by flash read masters and
// the flash read responder.
//   read          master -> slave  read request
//   address       master -> slave  23-bit word address
//   byteenable    master -> slave  byte lanes requested
//   waitrequest   slave -> master  request not accepted this cycle
//   readdata      slave -> master  returned data
//   readdatavalid slave -> master  one-cycle pulse per returned read
interface flash_mem_if;
    logic        read;
    logic [22:0] address;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        readdatavalid;

    modport master (
        output read, address, byteenable,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  read, address, byteenable,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/flash_read_responder.sv
// flash_read_responder: Avalon-MM read slave standing in for the flash
// controller. Holds off each read for WAIT_CYCLES cycles, allows at most
// DEPTH reads in flight, fetches words from a synchronous backing store and
// returns them in order exactly LATENCY cycles after acceptance. Also flags
// masters that drop or change a request while it is being held off.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   flash_mem     slave side of the flash read bus
//   store_rd      backing-store read strobe (the accept cycle)
//   store_addr    backing-store word address (request address)
//   store_q       backing-store data, valid the cycle after store_rd
//   protocol_err  sticky master protocol violation, cleared by reset
module flash_read_responder #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned LATENCY     = 3,
    parameter int unsigned DEPTH       = 2
) (
    input  logic        clk,
    input  logic        rst,
    flash_mem_if.slave  flash_mem,
    output logic        store_rd,
    output logic [22:0] store_addr,
    input  logic [31:0] store_q,
    output logic        protocol_err
);

    localparam logic [3:0] WAIT_LIM  = 4'(WAIT_CYCLES);
    localparam logic [3:0] DEPTH_LIM = 4'(DEPTH);

    // Wait-state counter and in-flight count
    logic [3:0]  wcnt_q, wcnt_d;
    logic [3:0]  outstanding_q, outstanding_d;

    // Return pipe: pv_q[i] marks a read in stage i+1. Stage 1 data is the
    // live store_q (masked with be_q); pdata_q[i] holds the last data that
    // left stage i+1.
    logic        pv_q    [LATENCY];
    logic        pv_d    [LATENCY];
    logic [31:0] pdata_q [LATENCY];
    logic [31:0] pdata_d [LATENCY];
    logic [31:0] stage_data [LATENCY];
    logic [3:0]  be_q, be_d;

    // Previous-cycle request, for the hold-under-waitrequest check
    logic        prev_read_q, prev_read_d;
    logic        prev_wait_q, prev_wait_d;
    logic [22:0] prev_addr_q, prev_addr_d;
    logic [3:0]  prev_be_q, prev_be_d;
    logic        err_q, err_d;

    logic        wait_ok;
    logic        full;
    logic        waitreq;
    logic        accept;
    logic        rdv;

    function automatic logic [31:0] mask_bytes(input logic [31:0] d,
                                               input logic [3:0]  be);
        logic [31:0] m;
        m = '0;
        for (int unsigned b = 0; b < 4; b++) begin
            if (be[b]) m[8*b +: 8] = d[8*b +: 8];
        end
        return m;
    endfunction

    // Handshake: fullness uses the registered count, so a slot freed by a
    // return only becomes visible the cycle after that return.
    always_comb begin
        wait_ok = (wcnt_q == WAIT_LIM);
        full    = (outstanding_q == DEPTH_LIM);
        waitreq = rst | ~wait_ok | full;
        accept  = ~rst & flash_mem.read & wait_ok & ~full;
        rdv     = pv_q[LATENCY-1];
    end

    always_comb begin
        wcnt_d = wcnt_q;
        if (accept || !flash_mem.read) begin
            wcnt_d = '0;
        end else if (wcnt_q != WAIT_LIM) begin
            wcnt_d = wcnt_q + 4'd1;
        end
    end

    always_comb begin
        outstanding_d = outstanding_q;
        if (accept && !rdv) begin
            outstanding_d = outstanding_q + 4'd1;
        end else if (!accept && rdv) begin
            outstanding_d = outstanding_q - 4'd1;
        end
    end

    // Byte masking is applied as store_q enters the pipe, so later stages
    // carry data only; byteenable is needed for stage 1 alone.
    always_comb begin
        stage_data    = '{default: '0};
        stage_data[0] = mask_bytes(store_q, be_q);
        for (int unsigned i = 1; i < LATENCY; i++) begin
            stage_data[i] = pdata_q[i-1];
        end
    end

    // Data registers load only when their stage holds a read, which keeps
    // the final register equal to the last returned word while idle.
    always_comb begin
        pv_d    = '{default: 1'b0};
        pdata_d = '{default: '0};
        pv_d[0] = accept;
        be_d    = accept ? flash_mem.byteenable : be_q;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            pv_d[i] = pv_q[i-1];
        end
        for (int unsigned i = 0; i < LATENCY; i++) begin
            pdata_d[i] = pv_q[i] ? stage_data[i] : pdata_q[i];
        end
    end

    // A violation needs a held-off read last cycle and a held-off cycle now.
    always_comb begin
        prev_read_d = flash_mem.read;
        prev_wait_d = waitreq;
        prev_addr_d = flash_mem.address;
        prev_be_d   = flash_mem.byteenable;
        err_d       = err_q;
        if (waitreq && prev_read_q && prev_wait_q &&
            (!flash_mem.read ||
             (flash_mem.address != prev_addr_q) ||
             (flash_mem.byteenable != prev_be_q))) begin
            err_d = 1'b1;
        end
    end

    always_comb begin
        flash_mem.waitrequest   = waitreq;
        flash_mem.readdatavalid = rdv;
        flash_mem.readdata      = rdv ? stage_data[LATENCY-1] : pdata_q[LATENCY-1];
        store_rd                = accept;
        store_addr              = flash_mem.address;
        protocol_err            = err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q        <= '0;
            outstanding_q <= '0;
            pv_q          <= '{default: 1'b0};
            pdata_q       <= '{default: '0};
            be_q          <= '0;
            prev_read_q   <= 1'b0;
            prev_wait_q   <= 1'b0;
            prev_addr_q   <= '0;
            prev_be_q     <= '0;
            err_q         <= 1'b0;
        end else begin
            wcnt_q        <= wcnt_d;
            outstanding_q <= outstanding_d;
            pv_q          <= pv_d;
            pdata_q       <= pdata_d;
            be_q          <= be_d;
            prev_read_q   <= prev_read_d;
            prev_wait_q   <= prev_wait_d;
            prev_addr_q   <= prev_addr_d;
            prev_be_q     <= prev_be_d;
            err_q         <= err_d;
        end
    end

endmodule
